// File: rtl/rd_arbiter.sv
// -----------------------------------------------------------------------------
// rd_arbiter
//   Round-robin arbiter granting N requesters access to one shared read
//   engine. Each transaction runs IDLE -> START -> WAIT -> RELEASE -> IDLE.
//   All outputs are registered and decoded from the next state and owner,
//   so no input reaches an output combinationally.
//
// Parameters
//   N        number of requesters (2..8)
//   TIMEOUT  WAIT-state cycle limit when the timeout feature is built (1..255)
//
// Optional feature
//   RD_ARBITER_TIMEOUT_EN  when defined, WAIT is bounded by TIMEOUT cycles and
//                          a bounded-out transaction completes with err = 1.
//                          When undefined, WAIT is unbounded and err is 0.
//
// Ports
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   [N] level read requests, sampled only in IDLE
//   gnt      out  [N] one-hot grant, held through START and WAIT
//   done     out  [N] one-cycle completion pulse to the owner (RELEASE)
//   go       out  start strobe to the read engine, one cycle (START)
//   ds       in   completion strobe from the read engine
//   busy     out  high in every state except IDLE
//   err      out  timeout pulse, coincident with done
// -----------------------------------------------------------------------------
module rd_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] done,
  output logic         go,
  input  logic         ds,
  output logic         busy,
  output logic         err
);

  localparam int unsigned OW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;   // doubles as last_owner for round-robin
  logic [OW-1:0] rr_pick;
  int unsigned   rr_idx;
  logic [OW-1:0] rr_idx_w;
  logic          rr_found;

  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic          go_q, go_d;
  logic          busy_q, busy_d;

`ifdef RD_ARBITER_TIMEOUT_EN
  logic [7:0]    cnt_q, cnt_d;
  logic          tmo_hit;
  logic          err_q;
`endif

  // Round-robin pick: first set request searching from owner_q+1 upward.
  always_comb begin
    rr_pick  = owner_q;
    rr_found = 1'b0;
    rr_idx   = 0;
    rr_idx_w = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      rr_idx   = (32'(owner_q) + i) % N;
      rr_idx_w = OW'(rr_idx);
      if (!rr_found && req[rr_idx_w]) begin
        rr_pick  = rr_idx_w;
        rr_found = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifdef RD_ARBITER_TIMEOUT_EN
    tmo_hit = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_START;
          owner_d = rr_pick;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (ds) begin
          state_d = S_RELEASE;
        end
`ifdef RD_ARBITER_TIMEOUT_EN
        // Counter holds the number of completed ds=0 WAIT cycles, so the
        // limit is reached at the end of the TIMEOUT-th WAIT cycle.
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = S_RELEASE;
          tmo_hit = 1'b1;
        end
`endif
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

`ifdef RD_ARBITER_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == S_WAIT && state_q != S_WAIT) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT && !ds) begin
      cnt_d = cnt_q + 8'd1;
    end
  end
`endif

  // Output decode from next state / next owner.
  always_comb begin
    gnt_d  = '0;
    done_d = '0;
    go_d   = 1'b0;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START: begin
        gnt_d = ONE << owner_d;
        go_d  = 1'b1;
      end
      S_WAIT:    gnt_d  = ONE << owner_d;
      S_RELEASE: done_d = ONE << owner_d;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      owner_q <= OW'(N - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef RD_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
`ifdef RD_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= tmo_hit;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign go   = go_q;
  assign busy = busy_q;
`ifdef RD_ARBITER_TIMEOUT_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rd_arbiter
//   Scoreboard bench for rd_arbiter (N=4, TIMEOUT=16). The stimulus process
//   runs transactions and, at each go strobe, pushes the expected owner,
//   grant length and err flag computed from the arbitration rules. A monitor
//   pops and compares on every done pulse and checks per-cycle invariants.
// -----------------------------------------------------------------------------
module tb_rd_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt, done;
  logic         go, ds = 1'b0, busy, err;

  rd_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .gnt(gnt), .done(done),
    .go(go), .ds(ds), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned owner;
    int unsigned len;
    bit          err;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned last_owner = N - 1;

  task automatic chk(input string name, input int unsigned got, input int unsigned want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference arbitration: first requester at or after last_owner+1 (mod N).
  function automatic int unsigned model_pick(input logic [N-1:0] r);
    for (int unsigned i = 1; i <= N; i++) begin
      if (r[(last_owner + i) % N]) return (last_owner + i) % N;
    end
    return last_owner;
  endfunction

  // d = WAIT cycle (1-based) in which ds is raised; dropv replaces req in
  // the first WAIT cycle when drop is set.
  task automatic run_txn(input logic [N-1:0] reqv, input int unsigned d,
                         input bit drop, input logic [N-1:0] dropv,
                         input int unsigned gap);
    int unsigned owner, waitn;
    bit          e, got;
    exp_t        x;
    req = '0;
    repeat (gap) begin @(posedge clock); #1; end
    req = reqv;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clock); #1;
      if (go) got = 1'b1;
    end
    if (!got) begin
      chk("go_timeout", 0, 1);
      ds = 1'b0;
      return;
    end
    owner = model_pick(reqv);
    last_owner = owner;
    waitn = d;
    e = 1'b0;
`ifdef RD_ARBITER_TIMEOUT_EN
    if (d > TO) begin
      waitn = TO;
      e = 1'b1;
    end
`endif
    x.owner = owner; x.len = 1 + waitn; x.err = e;
    sb_q.push_back(x);
    ds = 1'($urandom_range(0, 1));   // START ignores ds
    for (int unsigned j = 1; j <= waitn; j++) begin
      @(posedge clock); #1;
      ds = (j == d);
      if (drop && j == 1) req = dropv;
    end
    @(posedge clock); #1;             // RELEASE
    ds = 1'b0;
  endtask

  // Monitor: pops the scoreboard on done and checks per-cycle invariants.
  int unsigned run_len    = 0;
  int unsigned since_done = 100;
  logic [N-1:0] prev_gnt  = '0;

  always @(negedge clock) begin
    if (!reset_n) begin
      run_len    = 0;
      since_done = 100;
      prev_gnt   = '0;
    end else begin
      exp_t x;
      if (since_done < 100) since_done++;
      chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
      chk("busy", 32'(busy), 32'((|gnt) | (|done)));
      if (err && done == '0) chk("err_without_done", 32'(err), 0);
      if (go) begin
        chk("go_gnt_nonzero", 32'(gnt != '0), 1);
        chk("go_first_cycle", 32'(prev_gnt), 0);
        chk("go_spacing", 32'(since_done >= 2), 1);
      end
      if (gnt != '0) run_len++;
      if (done != '0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 0);
        end else begin
          x = sb_q.pop_front();
          chk("done_owner", 32'(done), 32'(1 << x.owner));
          chk("err", 32'(err), 32'(x.err));
          chk("gnt_len", run_len, x.len);
          chk("gnt_off_at_done", 32'(gnt), 0);
        end
        run_len    = 0;
        since_done = 0;
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #3;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_go", 32'(go), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Single request, ds in WAIT cycle 3 -> gnt 4 cycles.
    run_txn(4'b0001, 3, 1'b0, '0, 0);
    // Fairness with all requesting: 1,2,3,0,1 (last owner is 0).
    for (int k = 0; k < 5; k++) run_txn(4'b1111, 1 + k % 3, 1'b0, '0, 0);
    // Drop req[2] in WAIT.
    run_txn(4'b0100, 4, 1'b1, 4'b0000, 1);

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      run_txn(4'($urandom_range(1, 15)), $urandom_range(1, 6),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              $urandom_range(0, 2));
    end

`ifdef RD_ARBITER_TIMEOUT_EN
    run_txn(4'b1000, TO + 5, 1'b0, '0, 0);   // times out
    run_txn(4'b0010, TO, 1'b0, '0, 0);       // ds on the limit cycle wins
`else
    run_txn(4'b1000, 300, 1'b0, '0, 0);      // unbounded WAIT
`endif

    // Reset mid-WAIT while requester 1 owns the engine.
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    last_owner = N - 1;
    req = 4'b0010;
    begin
      bit got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(posedge clock); #1;
        if (go) got = 1'b1;
      end
      chk("rw_go_seen", 32'(got), 1);
      chk("rw_gnt", 32'(gnt), 32'(4'b0010));
    end
    @(posedge clock); #1;
    @(posedge clock); #1;                    // in WAIT
    chk("rw_gnt_wait", 32'(gnt), 32'(4'b0010));
    reset_n = 1'b0;
    #1;
    chk("rw_gnt0", 32'(gnt), 0);
    chk("rw_done0", 32'(done), 0);
    chk("rw_go0", 32'(go), 0);
    chk("rw_busy0", 32'(busy), 0);
    chk("rw_err0", 32'(err), 0);
    req = '0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    last_owner = N - 1;
    run_txn(4'b1010, 2, 1'b0, '0, 1);        // requester 1 first
    run_txn(4'b1010, 2, 1'b0, '0, 0);        // then requester 3

    req = '0;
    repeat (5) begin @(posedge clock); #1; end
    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
